// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, bit-period math and a 2-of-3 vote helper.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        START_BIT = 2'd1,
        DATA_BITS = 2'd2,
        STOP_BIT  = 2'd3
    } uart_state_e;

    // One definition of the bit timer for both transmitter and receiver.
    function automatic logic [15:0] calc_clk_per_baud(input int clk_freq_mhz, input int baud);
        int ratio;
        ratio = (clk_freq_mhz * 1_000_000) / baud;
        return ratio[15:0];
    endfunction

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the serial line plus a registered copy for falling-edge detect.
module uart_rx_sync (
    input  logic clk,
    input  logic reset,
    input  logic rx,
    output logic rx_s,
    output logic fall
);

    logic rx_meta;
    logic rx_sync;
    logic rx_d;

    // Flops reset to the idle-high line level so leaving reset never looks like an edge on an idle line.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            rx_d    <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_sync <= rx_meta;
            rx_d    <= rx_sync;
        end
    end

    assign rx_s = rx_sync;
    assign fall = rx_d & ~rx_sync;

endmodule

// File: rtl/uart_rx_state_machine.sv
// 8N1 UART receiver, LSB first, bit period clk_per_baud+1 clocks (matches the transmitter).
// Define UART_RX_MAJORITY_EN to take each sample as a 2-of-3 vote over the last three rx_s values.
//
//   state     | meaning
//   IDLE      | waiting for a falling edge on rx_s, counter held at 0
//   START_BIT | timing to mid start bit, rejecting false starts
//   DATA_BITS | sampling 8 data bits one bit period apart
//   STOP_BIT  | sampling the stop bit, then valid or frame_err
module uart_rx_state_machine
    import uart_pkg::*;
#(
    parameter int baudrate     = 187_500,
    parameter int clk_freq_MHz = 80
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    output logic [7:0] data,
    output logic       valid,
    output logic       frame_err,
    output logic       busy
);

    localparam logic [15:0] CLK_PER_BAUD = calc_clk_per_baud(clk_freq_MHz, baudrate);
    localparam int          HALF_PERIOD  = (int'(CLK_PER_BAUD) + 1) / 2;
    localparam logic [15:0] HALF_M1      = 16'(HALF_PERIOD - 1);

    uart_state_e state;
    uart_state_e state_nxt;
    logic [15:0] cnt;
    logic [2:0]  bit_idx;
    logic [7:0]  shift_reg;
    logic        rx_s;
    logic        fall;
    logic        sample_bit;
    logic        tick;
    logic        load_data;
    logic        stop_err;

    uart_rx_sync u_sync (
        .clk   (clk),
        .reset (reset),
        .rx    (rx),
        .rx_s  (rx_s),
        .fall  (fall)
    );

`ifdef UART_RX_MAJORITY_EN
    logic rx_h1;
    logic rx_h2;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_h1 <= 1'b1;
            rx_h2 <= 1'b1;
        end else begin
            rx_h1 <= rx_s;
            rx_h2 <= rx_h1;
        end
    end

    assign sample_bit = maj3(rx_s, rx_h1, rx_h2);
`else
    assign sample_bit = rx_s;
`endif

    // Start bit decides at mid-bit; every later decision is one full bit period after the last.
    assign tick = (state == START_BIT) ? (cnt == HALF_M1) : (cnt == CLK_PER_BAUD);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:      if (fall) state_nxt = START_BIT;
            START_BIT: if (tick) state_nxt = sample_bit ? IDLE : DATA_BITS;
            DATA_BITS: if (tick && bit_idx == 3'd7) state_nxt = STOP_BIT;
            STOP_BIT:  if (tick) state_nxt = IDLE;
            default:   state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy      = (state != IDLE);
        load_data = (state == STOP_BIT) && tick && sample_bit;
        stop_err  = (state == STOP_BIT) && tick && !sample_bit;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt       <= 16'd0;
            bit_idx   <= 3'd0;
            shift_reg <= 8'h00;
            data      <= 8'h00;
            valid     <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            cnt       <= (state == IDLE || tick) ? 16'd0 : cnt + 16'd1;
            valid     <= load_data;
            frame_err <= stop_err;
            if (state == START_BIT) begin
                bit_idx <= 3'd0;
            end else if (state == DATA_BITS && tick) begin
                bit_idx   <= bit_idx + 3'd1;
                shift_reg <= {sample_bit, shift_reg[7:1]};
            end
            if (load_data) begin
                data <= shift_reg;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_state_machine.sv
// Directed bench for uart_rx_state_machine: table of 8N1 frames plus hand-written corner sequences.
module tb_uart_rx_state_machine;

    localparam int BIT_CLKS   = 427;
    localparam int PULSE_OFS  = 4059;   // rx pin fall to first negedge with valid/frame_err visible
    localparam int FRAME_CLKS = 10 * BIT_CLKS;
`ifdef UART_RX_MAJORITY_EN
    localparam logic [7:0] EXP_GLITCH = 8'h0F;
`else
    localparam logic [7:0] EXP_GLITCH = 8'h07;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       rx = 1'b1;
    logic [7:0] data;
    logic       valid;
    logic       frame_err;
    logic       busy;

    int cyc = 0;
    int checks = 0;
    int failures = 0;
    int valid_cnt = 0;
    int ferr_cnt = 0;
    int last_valid_cyc = -1;
    int prev_valid_cyc = -1;
    int last_ferr_cyc = -1;
    int overlap = 0;
    int wide = 0;
    logic valid_q = 1'b0;
    logic ferr_q = 1'b0;

    typedef struct {
        logic [7:0] din;
        logic       stop;
        logic       exp_valid;
        logic [7:0] exp_data;
    } vec_t;

    vec_t vecs[7];

    uart_rx_state_machine dut (
        .clk       (clk),
        .reset     (reset),
        .rx        (rx),
        .data      (data),
        .valid     (valid),
        .frame_err (frame_err),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (valid) begin
            valid_cnt++;
            prev_valid_cyc = last_valid_cyc;
            last_valid_cyc = cyc;
        end
        if (frame_err) begin
            ferr_cnt++;
            last_ferr_cyc = cyc;
        end
        if (valid && frame_err) overlap = 1;
        if ((valid && valid_q) || (frame_err && ferr_q)) wide = 1;
        valid_q = valid;
        ferr_q  = frame_err;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic wait_edges(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Drives one frame starting now; gb selects a data bit that gets a 1-cycle inverted glitch mid-bit.
    task automatic send_byte(input logic [7:0] b, input logic stop, input int gb);
        rx = 1'b0;
        wait_edges(BIT_CLKS);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            if (i == gb) begin
                wait_edges(213);
                rx = ~b[i];
                wait_edges(1);
                rx = b[i];
                wait_edges(213);
            end else begin
                wait_edges(BIT_CLKS);
            end
        end
        rx = stop;
        wait_edges(BIT_CLKS);
    endtask

    initial begin
        int n0;
        int v0;
        int f0;

        vecs[0] = '{8'hA5, 1'b1, 1'b1, 8'hA5};
        vecs[1] = '{8'h3C, 1'b0, 1'b0, 8'hA5};
        vecs[2] = '{8'h00, 1'b1, 1'b1, 8'h00};
        vecs[3] = '{8'hFF, 1'b1, 1'b1, 8'hFF};
        vecs[4] = '{8'h5A, 1'b1, 1'b1, 8'h5A};
        vecs[5] = '{8'h81, 1'b0, 1'b0, 8'h5A};
        vecs[6] = '{8'h01, 1'b1, 1'b1, 8'h01};

        wait_edges(5);
        check("reset_data", 32'(data), 32'h00);
        check("reset_valid", 32'(valid), 32'h0);
        check("reset_frame_err", 32'(frame_err), 32'h0);
        check("reset_busy", 32'(busy), 32'h0);
        reset = 1'b1;
        wait_edges(10);

        for (int i = 0; i < 7; i++) begin
            v0 = valid_cnt;
            f0 = ferr_cnt;
            n0 = cyc;
            send_byte(vecs[i].din, vecs[i].stop, -1);
            check($sformatf("vec%0d_valid_cnt", i), 32'(valid_cnt - v0), 32'(vecs[i].exp_valid));
            check($sformatf("vec%0d_ferr_cnt", i), 32'(ferr_cnt - f0), 32'(!vecs[i].exp_valid));
            if (vecs[i].exp_valid)
                check($sformatf("vec%0d_valid_time", i), 32'(last_valid_cyc - n0), 32'(PULSE_OFS));
            else
                check($sformatf("vec%0d_ferr_time", i), 32'(last_ferr_cyc - n0), 32'(PULSE_OFS));
            check($sformatf("vec%0d_data", i), 32'(data), 32'(vecs[i].exp_data));
            check($sformatf("vec%0d_busy_after", i), 32'(busy), 32'h0);
            if (i > 0 && vecs[i-1].stop && vecs[i].exp_valid)
                check($sformatf("vec%0d_b2b_gap", i), 32'(last_valid_cyc - prev_valid_cyc), 32'(FRAME_CLKS));
            if (!vecs[i].stop) begin
                rx = 1'b1;
                wait_edges(20);
            end
        end

        // False start: low for 100 clocks, rejected at the mid-start-bit sample.
        v0 = valid_cnt;
        f0 = ferr_cnt;
        n0 = cyc;
        rx = 1'b0;
        wait_edges(2);
        check("fs_busy_before_t0", 32'(busy), 32'h0);
        wait_edges(1);
        check("fs_busy_t0p1", 32'(busy), 32'h1);
        wait_edges(97);
        rx = 1'b1;
        wait_edges(115);
        check("fs_busy_t0p213", 32'(busy), 32'h1);
        wait_edges(1);
        check("fs_busy_t0p214", 32'(busy), 32'h0);
        wait_edges(FRAME_CLKS);
        check("fs_no_valid", 32'(valid_cnt - v0), 32'h0);
        check("fs_no_ferr", 32'(ferr_cnt - f0), 32'h0);

        // Bad stop bit followed by a held-low line: exactly one frame_err.
        v0 = valid_cnt;
        f0 = ferr_cnt;
        send_byte(8'h3C, 1'b0, -1);
        wait_edges(5000);
        check("break_one_ferr", 32'(ferr_cnt - f0), 32'h1);
        check("break_no_valid", 32'(valid_cnt - v0), 32'h0);
        check("break_data_kept", 32'(data), 32'h01);
        check("break_busy", 32'(busy), 32'h0);
        rx = 1'b1;
        wait_edges(20);

        // Reset in the middle of bit 4 of 0x5A, then a clean 0x81.
        v0 = valid_cnt;
        f0 = ferr_cnt;
        rx = 1'b0;
        wait_edges(BIT_CLKS);
        for (int i = 0; i < 4; i++) begin
            rx = (i % 2 == 1);
            wait_edges(BIT_CLKS);
        end
        rx = 1'b1;
        wait_edges(200);
        check("mid_busy_before_rst", 32'(busy), 32'h1);
        reset = 1'b0;
        #1;
        check("mid_rst_data", 32'(data), 32'h00);
        check("mid_rst_busy", 32'(busy), 32'h0);
        wait_edges(3);
        reset = 1'b1;
        wait_edges(600);
        check("mid_no_valid", 32'(valid_cnt - v0), 32'h0);
        check("mid_no_ferr", 32'(ferr_cnt - f0), 32'h0);
        n0 = cyc;
        send_byte(8'h81, 1'b1, -1);
        check("mid_next_valid_cnt", 32'(valid_cnt - v0), 32'h1);
        check("mid_next_valid_time", 32'(last_valid_cyc - n0), 32'(PULSE_OFS));
        check("mid_next_data", 32'(data), 32'h81);
        wait_edges(20);

        // Single-cycle glitch exactly at the bit-3 sample point.
        v0 = valid_cnt;
        send_byte(8'h0F, 1'b1, 3);
        check("glitch_valid_cnt", 32'(valid_cnt - v0), 32'h1);
        check("glitch_data", 32'(data), 32'(EXP_GLITCH));
        wait_edges(20);

        check("pulse_overlap", 32'(overlap), 32'h0);
        check("pulse_width", 32'(wide), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
